// File: rtl/bin2bcd_seq_pkg.sv
// Shared constants and FSM state type for the sequential binary-to-BCD converter.
package bin2bcd_seq_pkg;

  localparam int unsigned MAX_DEC   = 9999;
  localparam int unsigned NDIG      = 4;
  localparam logic [3:0]  OVF_DIGIT = 4'hF;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOp   = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between the converter and its user (display mux side).
interface bin2bcd_seq_if #(
  parameter int unsigned BIN_W = 14
);

  logic             start;
  logic [BIN_W-1:0] bin;
  logic             ready;
  logic             done_tick;
  logic [3:0]       bcd3;
  logic [3:0]       bcd2;
  logic [3:0]       bcd1;
  logic [3:0]       bcd0;
  logic             ovf;

  modport master (
    output start, bin,
    input  ready, done_tick, bcd3, bcd2, bcd1, bcd0, ovf
  );

  modport slave (
    input  start, bin,
    output ready, done_tick, bcd3, bcd2, bcd1, bcd0, ovf
  );

endinterface

// File: rtl/bin2bcd_seq_bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more before the shift.
module bin2bcd_seq_bcd_add3 (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  // Inputs are at most 9, so d+3 never exceeds 12 and fits in 4 bits.
  assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int unsigned BIN_W = 14
) (
  input  logic               clk,
  input  logic               reset,
  bin2bcd_seq_if.slave       bus
);

  localparam int unsigned CntW = $clog2(BIN_W + 1);
  localparam int unsigned AccW = 4 * NDIG + BIN_W;

  state_e                    state_q;
  logic [BIN_W-1:0]          sreg_q;
  logic [NDIG-1:0][3:0]      w_q;
  logic [CntW-1:0]           cnt_q;
  logic                      ovf_pend_q;
  logic                      ready_q;
  logic                      done_q;
  logic [NDIG-1:0][3:0]      bcd_q;
  logic                      ovf_q;

  logic [NDIG-1:0][3:0]      w_adj;
  logic [AccW-1:0]           acc_shift;
  logic [NDIG-1:0][3:0]      w_d;
  logic [BIN_W-1:0]          sreg_d;
  logic                      bin_ovf;

  for (genvar g = 0; g < NDIG; g++) begin : g_digit
    bin2bcd_seq_bcd_add3 u_add3 (
      .d_i (w_q[g]),
      .d_o (w_adj[g])
    );
  end

  // Corrected digits and the remaining binary bits shift as one register.
  assign acc_shift = {w_adj, sreg_q} << 1;
  assign w_d       = acc_shift[AccW-1:BIN_W];
  assign sreg_d    = acc_shift[BIN_W-1:0];

  // Zero-extended compare; folds to constant 0 when BIN_W cannot exceed MAX_DEC.
  assign bin_ovf = (32'(bus.bin) > MAX_DEC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      sreg_q     <= '0;
      w_q        <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            sreg_q     <= bus.bin;
            w_q        <= '0;
            cnt_q      <= CntW'(BIN_W);
            ovf_pend_q <= bin_ovf;
            ready_q    <= 1'b0;
            state_q    <= StOp;
          end
        end
        StOp: begin
          sreg_q <= sreg_d;
          w_q    <= w_d;
          cnt_q  <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            bcd_q   <= ovf_pend_q ? {NDIG{OVF_DIGIT}} : w_d;
            ovf_q   <= ovf_pend_q;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.ready     = ready_q;
  assign bus.done_tick = done_q;
  assign bus.bcd3      = bcd_q[3];
  assign bus.bcd2      = bcd_q[2];
  assign bus.bcd1      = bcd_q[1];
  assign bus.bcd0      = bcd_q[0];
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq with hand-computed BCD results.
module tb_bin2bcd_seq;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_err;

  bin2bcd_seq_if #(.BIN_W(14)) bus ();

  bin2bcd_seq #(.BIN_W(14)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] bcd_all;
  assign bcd_all = {bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts one conversion and returns the number of edges after the start edge until done.
  task automatic conv(input logic [13:0] b, output int lat);
    @(negedge clk);
    bus.bin   = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done_tick) break;
    end
  endtask

  task automatic conv_chk(input string tag, input logic [13:0] b,
                          input logic [15:0] exp_bcd, input logic exp_ovf);
    int lat;
    conv(b, lat);
    chk({tag, "_lat"}, lat, 14);
    chk({tag, "_bcd"}, bcd_all, exp_bcd);
    chk({tag, "_ovf"}, bus.ovf, exp_ovf);
    chk({tag, "_rdy_at_done"}, bus.ready, 1'b0);
    @(posedge clk);
    #1;
    chk({tag, "_rdy_after"}, bus.ready, 1'b1);
    chk({tag, "_done_once"}, bus.done_tick, 1'b0);
  endtask

  initial begin
    int pulses;
    int cyc;
    int t1, t2, t3;
    int unstable;
    logic [15:0] seen_bcd;

    n_checks  = 0;
    n_err     = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.bin   = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", bus.ready, 1'b1);
    chk("rst_done", bus.done_tick, 1'b0);
    chk("rst_bcd", bcd_all, 16'h0000);
    chk("rst_ovf", bus.ovf, 1'b0);
    reset = 1'b0;

    conv_chk("zero", 14'd0, 16'h0000, 1'b0);
    conv_chk("v4095", 14'd4095, 16'h4095, 1'b0);
    conv_chk("v9999", 14'd9999, 16'h9999, 1'b0);
    conv_chk("v10000", 14'd10000, 16'hFFFF, 1'b1);
    conv_chk("v16383", 14'd16383, 16'hFFFF, 1'b1);
    conv_chk("v7", 14'd7, 16'h0007, 1'b0);

    // Second start (and bin change) during OP must be ignored.
    @(negedge clk);
    bus.bin   = 14'd1234;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.bin   = 14'd5678;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    pulses   = 0;
    seen_bcd = '0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (bus.done_tick) begin
        pulses++;
        seen_bcd = bcd_all;
      end
    end
    chk("busy_start_pulses", pulses, 1);
    chk("busy_start_bcd", seen_bcd, 16'h1234);
    chk("busy_start_ready", bus.ready, 1'b1);

    // start held high: back-to-back conversions every BIN_W+2 cycles.
    @(negedge clk);
    bus.bin   = 14'd321;
    bus.start = 1'b1;
    cyc      = 0;
    pulses   = 0;
    unstable = 0;
    t1 = 0; t2 = 0; t3 = 0;
    while (cyc < 80 && pulses < 3) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.done_tick) begin
        pulses++;
        if (pulses == 1) t1 = cyc;
        if (pulses == 2) t2 = cyc;
        if (pulses == 3) t3 = cyc;
      end
      if (pulses >= 1 && bcd_all !== 16'h0321) unstable++;
    end
    bus.start = 1'b0;
    chk("held_pulses", pulses, 3);
    chk("held_first", t1, 15);
    chk("held_period1", t2 - t1, 16);
    chk("held_period2", t3 - t2, 16);
    chk("held_stable", unstable, 0);
    @(posedge clk);
    #1;
    chk("held_ready", bus.ready, 1'b1);

    // Reset in the middle of a conversion discards it.
    @(negedge clk);
    bus.bin   = 14'd8888;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_bcd", bcd_all, 16'h0000);
    chk("midrst_ready", bus.ready, 1'b1);
    chk("midrst_done", bus.done_tick, 1'b0);
    @(negedge clk);
    reset  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.done_tick) pulses++;
    end
    chk("midrst_no_done", pulses, 0);
    chk("midrst_hold_bcd", bcd_all, 16'h0000);

    conv_chk("v42", 14'd42, 16'h0042, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
